// File: rtl/gpio_pad_ctrl_pkg.sv
// Shared types and reset constants for the GPIO pad controller slice.
package gpio_pad_ctrl_pkg;

    localparam int unsigned DB_W_DEF    = 8;
    localparam int unsigned NUM_PIN_DEF = 8;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;

    localparam logic PAD_OEN_RST = 1'b0;
    localparam logic PAD_REN_RST = 1'b0;

endpackage

// File: rtl/gpio_pad_db.sv
// One pin's input path: 2-flop synchroniser, debounce counter, conditioned value and edge report.
module gpio_pad_db
    import gpio_pad_ctrl_pkg::*;
#(
    parameter int unsigned DB_W = DB_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            db_en_i,
    input  logic            tick_i,
    input  logic [DB_W-1:0] db_thr_i,
    input  logic            pad_c_i,
    output logic            in_o,
    output edge_e           edge_o
);

    logic            sync_1;
    logic            sync_2;
    logic [DB_W-1:0] cnt;
    logic            accept;

    // edge_o is combinational so the pending bit lands on the same edge as in_o
    always_comb begin
        accept = 1'b0;
        edge_o = EDGE_NONE;
        if (sync_2 != in_o) begin
            accept = !db_en_i || (tick_i && (cnt >= db_thr_i));
        end
        if (accept) begin
            edge_o = sync_2 ? EDGE_RISE : EDGE_FALL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            in_o   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= pad_c_i;
            sync_2 <= sync_1;
            if (accept) begin
                in_o <= sync_2;
            end
            // Holding the counter at zero while bypassed makes any db_en_i toggle start clean
            if (!db_en_i || (sync_2 == in_o) || accept) begin
                cnt <= '0;
            end else if (tick_i && (cnt != '1)) begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad sequencer: registered pad drive, shared debounce prescaler, pending bits and interrupt.
module gpio_pad_ctrl
    import gpio_pad_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PIN = NUM_PIN_DEF,
    parameter int unsigned DB_W    = DB_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_PIN-1:0] dir_i,
    input  logic [NUM_PIN-1:0] out_i,
    input  logic [NUM_PIN-1:0] pull_en_i,
    input  logic               db_en_i,
    input  logic [DB_W-1:0]    psc_i,
    input  logic [DB_W-1:0]    db_thr_i,
    input  logic [NUM_PIN-1:0] rise_en_i,
    input  logic [NUM_PIN-1:0] fall_en_i,
    input  logic [NUM_PIN-1:0] pend_clr_i,
    output logic [NUM_PIN-1:0] pad_i_o,
    output logic [NUM_PIN-1:0] pad_oen_o,
    output logic [NUM_PIN-1:0] pad_ren_o,
    input  logic [NUM_PIN-1:0] pad_c_i,
    output logic [NUM_PIN-1:0] in_o,
    output logic [NUM_PIN-1:0] pend_o,
    output logic               irq_o
);

    logic [DB_W-1:0]    psc_cnt;
    logic               tick;
    edge_e              edge_w [NUM_PIN];
    logic [NUM_PIN-1:0] pend_set;

    // >= rather than == so lowering psc_i below the running count ticks immediately
    always_comb begin
        tick = (psc_cnt >= psc_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            psc_cnt <= '0;
        end else if (tick) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + DB_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_PIN; g++) begin : g_pin
        gpio_pad_db #(
            .DB_W (DB_W)
        ) u_db (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .db_en_i  (db_en_i),
            .tick_i   (tick),
            .db_thr_i (db_thr_i),
            .pad_c_i  (pad_c_i[g]),
            .in_o     (in_o[g]),
            .edge_o   (edge_w[g])
        );
    end

    always_comb begin
        pend_set = '0;
        for (int unsigned n = 0; n < NUM_PIN; n++) begin
            pend_set[n] = ((edge_w[n] == EDGE_RISE) && rise_en_i[n]) ||
                          ((edge_w[n] == EDGE_FALL) && fall_en_i[n]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pad_oen_o <= {NUM_PIN{PAD_OEN_RST}};
            pad_ren_o <= {NUM_PIN{PAD_REN_RST}};
            pad_i_o   <= '0;
            pend_o    <= '0;
            irq_o     <= 1'b0;
        end else begin
            pad_oen_o <= dir_i;
            pad_ren_o <= pull_en_i;
            pad_i_o   <= out_i;
            // Set is ORed in after the clear so a colliding event survives
            pend_o    <= (pend_o & ~pend_clr_i) | pend_set;
            irq_o     <= |pend_o;
        end
    end

endmodule
